// File: rtl/status_flag_unit_if.sv
// rtl/status_flag_unit_if.sv - FIFO flag, W1C/enable register and status/irq signal bundle
// for status_flag_unit. The master drives the peripheral and register inputs; the slave is the unit.
interface status_flag_unit_if #(
    parameter int SW     = 5,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 4
);
    logic [SW-1:0]           i2c_status;
    logic [NUM_CH-1:0]       fifo_full;
    logic [NUM_CH-1:0]       fifo_empty;
    logic [NUM_CH-1:0]       fifo_wr;
    logic [NUM_CH-1:0]       fifo_rd;
    logic                    clr_we;
    logic [2*NUM_CH-1:0]     clr_data;
    logic                    en_we;
    logic [2*NUM_CH-1:0]     en_data;
    logic [SW+4*NUM_CH-1:0]  status_out;
    logic [2*NUM_CH-1:0]     irq_en_out;
    logic                    irq;
    logic [NUM_CH*CNT_W-1:0] err_cnt;

    modport master (
        output i2c_status, fifo_full, fifo_empty, fifo_wr, fifo_rd,
        output clr_we, clr_data, en_we, en_data,
        input  status_out, irq_en_out, irq, err_cnt
    );

    modport slave (
        input  i2c_status, fifo_full, fifo_empty, fifo_wr, fifo_rd,
        input  clr_we, clr_data, en_we, en_data,
        output status_out, irq_en_out, irq, err_cnt
    );
endinterface

// File: rtl/status_flag_unit.sv
// rtl/status_flag_unit.sv - sticky W1C overflow/underflow status aggregator with maskable irq.
// Define STATUS_ERR_CNT_EN to build the per-channel saturating error counters.
module status_flag_unit #(
    parameter int SW     = 5,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    status_flag_unit_if.slave bus
);
    localparam int EW = 2 * NUM_CH;

    logic [SW-1:0]          pstat_q;
    logic [NUM_CH-1:0]      full_q;
    logic [NUM_CH-1:0]      empty_q;
    logic [EW-1:0]          sticky_q;
    logic [EW-1:0]          sticky_d;
    logic [EW-1:0]          irq_en_q;
    logic [EW-1:0]          irq_en_d;
    logic [EW-1:0]          ev;
    logic [EW-1:0]          clr_mask;
    logic [SW+4*NUM_CH-1:0] status_vec;

    // Event vector uses the same interleaving as clr_data: even = overflow, odd = underflow.
    always_comb begin
        ev = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ev[2*c]   = bus.fifo_full[c] & bus.fifo_wr[c];
            ev[2*c+1] = bus.fifo_empty[c] & bus.fifo_rd[c];
        end
        clr_mask = bus.clr_we ? bus.clr_data : '0;
        sticky_d = (sticky_q & ~clr_mask) | ev;
        irq_en_d = bus.en_we ? bus.en_data : irq_en_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pstat_q  <= '0;
            full_q   <= '0;
            empty_q  <= '0;
            sticky_q <= '0;
            irq_en_q <= '0;
        end else begin
            pstat_q  <= bus.i2c_status;
            full_q   <= bus.fifo_full;
            empty_q  <= bus.fifo_empty;
            sticky_q <= sticky_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_comb begin
        status_vec         = '0;
        status_vec[SW-1:0] = pstat_q;
        for (int c = 0; c < NUM_CH; c++) begin
            status_vec[SW+4*c]   = empty_q[c];
            status_vec[SW+4*c+1] = full_q[c];
            status_vec[SW+4*c+2] = sticky_q[2*c];
            status_vec[SW+4*c+3] = sticky_q[2*c+1];
        end
    end

    assign bus.status_out = status_vec;
    assign bus.irq_en_out = irq_en_q;
    // Built only from flops so irq tracks status_out exactly with no input-to-irq path.
    assign bus.irq        = |(sticky_q & irq_en_q);

`ifdef STATUS_ERR_CNT_EN
    logic [CNT_W-1:0]        cnt_q [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] cnt_vec;

    // A clear coinciding with an event restarts the count at 1 rather than dropping the event.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_i) begin
                cnt_q[c] <= '0;
            end else if (clr_mask[2*c] | clr_mask[2*c+1]) begin
                cnt_q[c] <= (ev[2*c] | ev[2*c+1]) ? CNT_W'(1) : '0;
            end else if ((ev[2*c] | ev[2*c+1]) && (cnt_q[c] != {CNT_W{1'b1}})) begin
                cnt_q[c] <= cnt_q[c] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cnt_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_vec[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

    assign bus.err_cnt = cnt_vec;
`else
    assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_status_flag_unit.sv
// tb/tb_status_flag_unit.sv - directed and random checks of status_flag_unit against a
// per-channel behavioural model.
module tb_status_flag_unit;
    localparam int SW     = 5;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    status_flag_unit_if #(.SW(SW), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    status_flag_unit #(.SW(SW), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    bit                m_ovf   [NUM_CH];
    bit                m_unf   [NUM_CH];
    bit                m_en    [2*NUM_CH];
    int                m_cnt   [NUM_CH];
    logic [SW-1:0]     m_pstat;
    logic [NUM_CH-1:0] m_full;
    logic [NUM_CH-1:0] m_empty;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_pstat = '0; m_full = '0; m_empty = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_ovf[c] = 0; m_unf[c] = 0; m_cnt[c] = 0;
            end
            for (int i = 0; i < 2*NUM_CH; i++) m_en[i] = 0;
        end else begin
            m_pstat = bus.i2c_status; m_full = bus.fifo_full; m_empty = bus.fifo_empty;
            for (int c = 0; c < NUM_CH; c++) begin
                bit o, u, clr_o, clr_u;
                o     = bus.fifo_full[c] && bus.fifo_wr[c];
                u     = bus.fifo_empty[c] && bus.fifo_rd[c];
                clr_o = bus.clr_we && bus.clr_data[2*c];
                clr_u = bus.clr_we && bus.clr_data[2*c+1];
                m_ovf[c] = o ? 1 : (clr_o ? 0 : m_ovf[c]);
                m_unf[c] = u ? 1 : (clr_u ? 0 : m_unf[c]);
                if (clr_o || clr_u) m_cnt[c] = (o || u) ? 1 : 0;
                else if ((o || u) && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
            end
            if (bus.en_we)
                for (int i = 0; i < 2*NUM_CH; i++) m_en[i] = bus.en_data[i];
        end
    endtask

    task automatic step(input string tag);
        logic [63:0] e_stat, e_en, e_cnt;
        logic        e_irq;
        model_edge();
        @(posedge clk);
        #1;
        e_stat = 64'(m_pstat);
        e_en = '0; e_cnt = '0; e_irq = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            e_stat = e_stat | (64'(m_empty[c]) << (SW + 4*c)) | (64'(m_full[c]) << (SW + 4*c + 1))
                   | (64'(m_ovf[c]) << (SW + 4*c + 2)) | (64'(m_unf[c]) << (SW + 4*c + 3));
            if ((m_ovf[c] && m_en[2*c]) || (m_unf[c] && m_en[2*c+1])) e_irq = 1'b1;
`ifdef STATUS_ERR_CNT_EN
            e_cnt = e_cnt | (64'(m_cnt[c]) << (CNT_W*c));
`endif
        end
        for (int i = 0; i < 2*NUM_CH; i++) e_en[i] = m_en[i];
        check({tag, ".status"}, 64'(bus.status_out), e_stat);
        check({tag, ".irq_en"}, 64'(bus.irq_en_out), e_en);
        check({tag, ".irq"}, 64'(bus.irq), 64'(e_irq));
        check({tag, ".err_cnt"}, 64'(bus.err_cnt), e_cnt);
    endtask

    task automatic idle();
        bus.i2c_status = '0; bus.fifo_full = '0; bus.fifo_empty = '0;
        bus.fifo_wr = '0; bus.fifo_rd = '0; bus.clr_we = 1'b0; bus.clr_data = '0;
        bus.en_we = 1'b0; bus.en_data = '0; rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step("reset");
        check("reset.status_zero", 64'(bus.status_out), 64'd0);
        check("reset.irq_zero", 64'(bus.irq), 64'd0);
        rst = 1'b0;

        bus.i2c_status = 5'h15; bus.fifo_empty = 2'b11;
        step("t1");
        check("t1.status_const", 64'(bus.status_out), 64'h0235);

        idle();
        bus.fifo_full = 2'b01; bus.fifo_wr = 2'b01; bus.en_we = 1'b1; bus.en_data = 4'b0001;
        step("t2.set");
        check("t2.bit7", 64'(bus.status_out[7]), 64'd1);
        idle();
        step("t2.hold");
        check("t2.irq_held", 64'(bus.irq), 64'd1);

        bus.clr_we = 1'b1; bus.clr_data = 4'b0001;
        step("t3.clr");
        check("t3.irq_low", 64'(bus.irq), 64'd0);
        bus.fifo_full = 2'b01; bus.fifo_wr = 2'b01;
        step("t3.set_wins");
        check("t3.bit7_kept", 64'(bus.status_out[7]), 64'd1);

        idle();
        bus.clr_we = 1'b1; bus.clr_data = 4'b1111; bus.en_we = 1'b1; bus.en_data = 4'b0000;
        step("t4.prep");
        idle();
        bus.fifo_empty = 2'b10; bus.fifo_rd = 2'b10;
        step("t4.unf");
        check("t4.bit12", 64'(bus.status_out[12]), 64'd1);
        check("t4.masked", 64'(bus.irq), 64'd0);
        idle();
        bus.en_we = 1'b1; bus.en_data = 4'b1000;
        step("t4.enable");
        check("t4.irq_on", 64'(bus.irq), 64'd1);

        idle();
        bus.fifo_full = 2'b10; bus.fifo_wr = 2'b10;
        for (int i = 0; i < 20; i++) step("t5.ovf");
`ifdef STATUS_ERR_CNT_EN
        check("t5.saturated", 64'(bus.err_cnt[7:4]), 64'hF);
`else
        check("t5.no_counter", 64'(bus.err_cnt), 64'd0);
`endif
        idle();
        bus.clr_we = 1'b1; bus.clr_data = 4'b0100;
        step("t5.clr");
        check("t5.cleared", 64'(bus.err_cnt[7:4]), 64'd0);

        idle();
        bus.fifo_full = 2'b11; bus.fifo_wr = 2'b11; bus.fifo_empty = 2'b11; bus.fifo_rd = 2'b11;
        bus.en_we = 1'b1; bus.en_data = 4'b1111;
        step("t6.load");
        rst = 1'b1;
        step("t6.rst");
        check("t6.status_zero", 64'(bus.status_out), 64'd0);
        check("t6.irq_zero", 64'(bus.irq), 64'd0);
        idle();

        for (int n = 0; n < 400; n++) begin
            bus.i2c_status = SW'($urandom);
            bus.fifo_full  = NUM_CH'($urandom);
            bus.fifo_empty = NUM_CH'($urandom);
            bus.fifo_wr    = NUM_CH'($urandom);
            bus.fifo_rd    = NUM_CH'($urandom);
            bus.clr_we     = ($urandom_range(0, 3) == 0);
            bus.clr_data   = (2*NUM_CH)'($urandom);
            bus.en_we      = ($urandom_range(0, 5) == 0);
            bus.en_data    = (2*NUM_CH)'($urandom);
            rst            = ($urandom_range(0, 49) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
